// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station: default sizes and the ALU/branch opcode map.
package reservation_station_pkg;

    localparam int RS_SIZE_BIT_DEF   = 3;
    localparam int ROB_WIDTH_BIT_DEF = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_BLTU = 4'd14,
        OP_BGEU = 4'd15
    } alu_op_e;

endpackage

// File: rtl/reservation_station_alu.sv
// Combinational ALU: 32-bit wrap arithmetic/logic ops, and branch compares returning 1/0.
module reservation_station_alu
    import reservation_station_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_o
);

    logic [4:0] shamt_s;
    assign shamt_s = b_i[4:0];

    // Opcode decode and evaluation
    always_comb begin
        res_o = 32'd0;
        case (op_i)
            OP_ADD:  res_o = a_i + b_i;
            OP_SUB:  res_o = a_i - b_i;
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_SLL:  res_o = a_i << shamt_s;
            OP_SRL:  res_o = a_i >> shamt_s;
            OP_SRA:  res_o = $signed(a_i) >>> shamt_s;
            OP_SLT:  res_o = {31'd0, $signed(a_i) < $signed(b_i)};
            OP_SLTU: res_o = {31'd0, a_i < b_i};
            OP_BEQ:  res_o = {31'd0, a_i == b_i};
            OP_BNE:  res_o = {31'd0, a_i != b_i};
            OP_BLT:  res_o = {31'd0, $signed(a_i) < $signed(b_i)};
            OP_BGE:  res_o = {31'd0, $signed(a_i) >= $signed(b_i)};
            OP_BLTU: res_o = {31'd0, a_i < b_i};
            OP_BGEU: res_o = {31'd0, a_i >= b_i};
            default: res_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: dispatch, tag wakeup, single-issue select and a registered result broadcast.
// Define RS_OLDEST_FIRST_EN to select the ready entry oldest in ROB order instead of lowest index.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE_BIT   = RS_SIZE_BIT_DEF,
    parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     inst_valid,
    input  logic [3:0]               inst_op,
    input  logic [31:0]              inst_vj,
    input  logic [31:0]              inst_vk,
    input  logic                     inst_qj_busy,
    input  logic                     inst_qk_busy,
    input  logic [ROB_WIDTH_BIT-1:0] inst_qj,
    input  logic [ROB_WIDTH_BIT-1:0] inst_qk,
    input  logic [ROB_WIDTH_BIT-1:0] inst_dest,
    input  logic [ROB_WIDTH_BIT-1:0] rob_head,
    input  logic                     lsb_is_set,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_set_id,
    input  logic [31:0]              lsb_set_val,
    output logic                     full,
    output logic                     rs_is_set,
    output logic [ROB_WIDTH_BIT-1:0] rs_set_id,
    output logic [31:0]              rs_set_val
);

    localparam int RS_SIZE = 1 << RS_SIZE_BIT;

    typedef struct packed {
        logic                     busy_j;
        logic                     busy_k;
        logic [ROB_WIDTH_BIT-1:0] qj;
        logic [ROB_WIDTH_BIT-1:0] qk;
        logic [31:0]              vj;
        logic [31:0]              vk;
        logic [3:0]               op;
        logic [ROB_WIDTH_BIT-1:0] dest;
    } entry_t;

    logic [RS_SIZE-1:0]       valid_q, valid_d;
    entry_t                   ent_q [RS_SIZE];
    entry_t                   ent_d [RS_SIZE];
    logic                     rs_is_set_q;
    logic [ROB_WIDTH_BIT-1:0] rs_set_id_q;
    logic [31:0]              rs_set_val_q;

    logic [RS_SIZE-1:0]       ready_s, issue_oh_s, alloc_oh_s, free_s;
    logic                     sel_found_s, alloc_found_s, alloc_en_s, full_s;
    logic [RS_SIZE_BIT-1:0]   sel_idx_s, alloc_idx_s;
    entry_t                   new_ent_s;
    logic [31:0]              alu_res_s;

    // Operand wakeup: {busy, value} after checking both broadcast buses; LSB wins on a tag tie.
    function automatic logic [32:0] wake(input logic busy, input logic [ROB_WIDTH_BIT-1:0] q,
                                         input logic [31:0] v);
        logic [32:0] r;
        if (busy && lsb_is_set && (q == lsb_set_id)) begin
            r = {1'b0, lsb_set_val};
        end else if (busy && rs_is_set_q && (q == rs_set_id_q)) begin
            r = {1'b0, rs_set_val_q};
        end else begin
            r = {busy, v};
        end
        return r;
    endfunction

    assign full_s = &valid_q;

    // Ready vector from registered state only
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_s[i] = valid_q[i] & ~ent_q[i].busy_j & ~ent_q[i].busy_k;
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [ROB_WIDTH_BIT-1:0] age_s, best_age_s;
    logic                     take_s;

    // Oldest-first select: smallest distance from the ROB head, ties to the lower index
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        best_age_s  = '0;
        age_s       = '0;
        take_s      = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            age_s       = ent_q[i].dest - rob_head;
            take_s      = ready_s[i] & (~sel_found_s | (age_s < best_age_s));
            sel_idx_s   = take_s ? RS_SIZE_BIT'(i) : sel_idx_s;
            best_age_s  = take_s ? age_s : best_age_s;
            sel_found_s = sel_found_s | take_s;
        end
    end
`else
    logic rob_head_unused_s;
    assign rob_head_unused_s = ^rob_head;

    // Lowest-index select: scan downward so the last hit is the lowest ready entry
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            sel_found_s = sel_found_s | ready_s[i];
            sel_idx_s   = ready_s[i] ? RS_SIZE_BIT'(i) : sel_idx_s;
        end
    end
`endif

    // Issue one-hot and allocation; an entry issuing this cycle counts as free
    always_comb begin
        free_s        = ~valid_q;
        alloc_found_s = 1'b0;
        alloc_idx_s   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            issue_oh_s[i] = sel_found_s & (sel_idx_s == RS_SIZE_BIT'(i));
            free_s[i]     = free_s[i] | issue_oh_s[i];
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            alloc_found_s = alloc_found_s | free_s[i];
            alloc_idx_s   = free_s[i] ? RS_SIZE_BIT'(i) : alloc_idx_s;
        end
        alloc_en_s = inst_valid & ~full_s & ~clear & alloc_found_s;
        for (int i = 0; i < RS_SIZE; i++) begin
            alloc_oh_s[i] = alloc_en_s & (alloc_idx_s == RS_SIZE_BIT'(i));
        end
    end

    // Incoming entry, with same-cycle broadcast capture applied
    always_comb begin
        new_ent_s      = '0;
        new_ent_s.qj   = inst_qj;
        new_ent_s.qk   = inst_qk;
        new_ent_s.op   = inst_op;
        new_ent_s.dest = inst_dest;
        {new_ent_s.busy_j, new_ent_s.vj} = wake(inst_qj_busy, inst_qj, inst_vj);
        {new_ent_s.busy_k, new_ent_s.vk} = wake(inst_qk_busy, inst_qk, inst_vk);
    end

    // Entry next state: wakeup, then issue-free, allocation and flush
    always_comb begin
        valid_d = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            {ent_d[i].busy_j, ent_d[i].vj} = wake(ent_q[i].busy_j, ent_q[i].qj, ent_q[i].vj);
            {ent_d[i].busy_k, ent_d[i].vk} = wake(ent_q[i].busy_k, ent_q[i].qk, ent_q[i].vk);
            ent_d[i]   = alloc_oh_s[i] ? new_ent_s : ent_d[i];
            valid_d[i] = ~clear & (alloc_oh_s[i] | (valid_q[i] & ~issue_oh_s[i]));
        end
    end

    reservation_station_alu u_alu (
        .op_i  (ent_q[sel_idx_s].op),
        .a_i   (ent_q[sel_idx_s].vj),
        .b_i   (ent_q[sel_idx_s].vk),
        .res_o (alu_res_s)
    );

    // State and result registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q      <= '0;
            rs_is_set_q  <= 1'b0;
            rs_set_id_q  <= '0;
            rs_set_val_q <= 32'd0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else if (rdy_in) begin
            valid_q     <= valid_d;
            rs_is_set_q <= sel_found_s & ~clear;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            if (sel_found_s & ~clear) begin
                rs_set_id_q  <= ent_q[sel_idx_s].dest;
                rs_set_val_q <= alu_res_s;
            end
        end
    end

    assign full       = full_s;
    assign rs_is_set  = rs_is_set_q;
    assign rs_set_id  = rs_set_id_q;
    assign rs_set_val = rs_set_val_q;

endmodule
